// File: rtl/stopwatch_timer.sv
// Millisecond stopwatch: debounced start/stop/clear keys, tick prescaler and elapsed-time counter.
// Optional lap-freeze display mode is built when STOPWATCH_LAP_EN is defined.

module stopwatch_key_deb #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DEB_RELOAD = CNT_W'(DEB_CYCLES - 1);

  logic sync_q1, sync_q2, deb_lvl;
  logic [CNT_W-1:0] deb_cnt;

  // Down-counter runs only while the synchronised level disagrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      deb_lvl <= 1'b1;
      deb_cnt <= DEB_RELOAD;
      press   <= 1'b0;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == deb_lvl) begin
        deb_cnt <= DEB_RELOAD;
      end else if (deb_cnt == '0) begin
        deb_lvl <= sync_q2;
        deb_cnt <= DEB_RELOAD;
        press   <= ~sync_q2;
      end else begin
        deb_cnt <= deb_cnt - 1'b1;
      end
    end
  end
endmodule

// state | meaning
// IDLE  | stopped and cleared, prescaler held at 0
// RUN   | prescaler advancing, count increments on each tick
// PAUSE | count and prescaler frozen, sub-tick phase kept for resume
module stopwatch_timer #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TICK_HZ    = 1000,
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned MAX_MS     = 35_999_999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_ss,
  input  logic        key_clr,
  input  logic        key_lap,
  output logic [31:0] dec_data,
  output logic        running,
  output logic        wrap
);
  localparam int unsigned PRE_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);
  localparam logic [31:0] MAX_C = 32'(MAX_MS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t state, state_nxt;
  logic ss_evt, clr_evt;
  logic in_run, in_idle, tick;
  logic [PRE_W-1:0] pre_cnt, pre_nxt;
  logic [31:0] count, count_nxt, disp_nxt;
  logic wrap_nxt;

  stopwatch_key_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .clk(clk), .rst_n(rst_n), .key_raw(key_ss), .press(ss_evt)
  );

  stopwatch_key_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk(clk), .rst_n(rst_n), .key_raw(key_clr), .press(clr_evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == RUN);
    end
  end

  // Clear has priority over start/stop when both events land together.
  always_comb begin
    state_nxt = state;
    if (clr_evt) begin
      state_nxt = IDLE;
    end else if (ss_evt) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_run  = (state == RUN);
    in_idle = (state == IDLE);
  end

  assign tick = in_run && (pre_cnt == PRE_LAST);

  always_comb begin
    count_nxt = count;
    pre_nxt   = pre_cnt;
    wrap_nxt  = 1'b0;
    if (clr_evt) begin
      count_nxt = '0;
      pre_nxt   = '0;
    end else if (in_idle) begin
      pre_nxt = '0;
    end else if (in_run) begin
      if (tick) begin
        pre_nxt = '0;
        if (count == MAX_C) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count + 32'd1;
        end
      end else begin
        pre_nxt = pre_cnt + 1'b1;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_evt, lap_hold, lap_hold_nxt;
  logic [31:0] lap_latch, lap_latch_nxt;

  stopwatch_key_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .clk(clk), .rst_n(rst_n), .key_raw(key_lap), .press(lap_evt)
  );

  // Latch takes the pre-increment count, so a lap coincident with a tick shows the old value.
  always_comb begin
    lap_hold_nxt  = lap_hold;
    lap_latch_nxt = lap_latch;
    if (clr_evt) begin
      lap_hold_nxt = 1'b0;
    end else if (lap_evt && in_run) begin
      if (lap_hold) begin
        lap_hold_nxt = 1'b0;
      end else begin
        lap_hold_nxt  = 1'b1;
        lap_latch_nxt = count;
      end
    end
    disp_nxt = lap_hold_nxt ? lap_latch_nxt : count_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_hold  <= 1'b0;
      lap_latch <= '0;
    end else begin
      lap_hold  <= lap_hold_nxt;
      lap_latch <= lap_latch_nxt;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = key_lap;
  assign disp_nxt   = count_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= '0;
      count    <= '0;
      dec_data <= '0;
      wrap     <= 1'b0;
    end else begin
      pre_cnt  <= pre_nxt;
      count    <= count_nxt;
      dec_data <= disp_nxt;
      wrap     <= wrap_nxt;
    end
  end
endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed bench for stopwatch_timer with short timing: 10 clocks per tick, 4-cycle debounce, wrap after 25.
// Lap-specific expectations switch on STOPWATCH_LAP_EN.

module tb_stopwatch_timer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_ss, key_clr, key_lap;
  logic [31:0] dec_data;
  logic        running, wrap;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wraps;
  int t, t2, t3, t4, t5, t6, t7, t8;

  always #5 clk = ~clk;

  stopwatch_timer #(
    .CLK_HZ(1000), .TICK_HZ(100), .DEB_CYCLES(4), .MAX_MS(25)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_ss(key_ss), .key_clr(key_clr), .key_lap(key_lap),
    .dec_data(dec_data), .running(running), .wrap(wrap)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic goto(input int e);
    while (cyc < e) step(1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; key_ss = 1'b1; key_clr = 1'b1; key_lap = 1'b1;
    step(3);
    check("rst_dec", dec_data, 0);
    check("rst_running", 32'(running), 0);
    check("rst_wrap", 32'(wrap), 0);
    rst_n = 1'b1;
    step(10);
    check("idle_keys_dec", dec_data, 0);
    check("idle_keys_running", 32'(running), 0);

    // start from IDLE
    t = cyc; key_ss = 1'b0;
    goto(t + 6);  check("start_pre", 32'(running), 0);
    goto(t + 7);  check("start_run", 32'(running), 1);
    goto(t + 8);  key_ss = 1'b1;
    goto(t + 16); check("first_tick_pre", dec_data, 0);
    goto(t + 17); check("first_tick", dec_data, 1);
    goto(t + 56); check("count4", dec_data, 4);
    goto(t + 57); check("count5", dec_data, 5);

    // one-clock glitch while running
    key_ss = 1'b0;
    goto(t + 58); key_ss = 1'b1;
    goto(t + 67); check("glitch_count6", dec_data, 6);
    goto(t + 77); check("glitch_running", 32'(running), 1);
    check("count7", dec_data, 7);

    // pause keeps prescaler phase
    t2 = cyc; key_ss = 1'b0;
    goto(t2 + 6);   check("pause_pre", 32'(running), 1);
    goto(t2 + 7);   check("pause_state", 32'(running), 0);
    goto(t2 + 8);   key_ss = 1'b1;
    goto(t2 + 107); check("pause_hold", dec_data, 7);
    check("pause_running", 32'(running), 0);

    t3 = cyc; key_ss = 1'b0;
    goto(t3 + 6);  check("resume_pre", 32'(running), 0);
    goto(t3 + 7);  check("resume_run", 32'(running), 1);
    goto(t3 + 8);  key_ss = 1'b1;
    goto(t3 + 9);  check("resume_phase_early", dec_data, 7);
    goto(t3 + 10); check("resume_phase_tick", dec_data, 8);

    // clear while running
    t4 = cyc; key_clr = 1'b0;
    goto(t4 + 6); check("clr_pre_dec", dec_data, 8);
    goto(t4 + 7); check("clr_dec", dec_data, 0);
    check("clr_running", 32'(running), 0);
    goto(t4 + 8); key_clr = 1'b1;

    // wrap: 26 ticks from 0
    t5 = cyc; key_ss = 1'b0;
    wraps = 0;
    while (cyc < t5 + 268) begin
      step(1);
      if (cyc == t5 + 8) key_ss = 1'b1;
      if (wrap) wraps++;
      if (cyc == t5 + 266) check("wrap_at_max", dec_data, 25);
      if (cyc == t5 + 267) begin
        check("wrap_to_zero", dec_data, 0);
        check("wrap_pulse", 32'(wrap), 1);
      end
    end
    check("wrap_pulse_end", 32'(wrap), 0);
    check("wrap_pulse_count", 32'(wraps), 1);

    // asynchronous reset mid-tick
    goto(t5 + 277); check("pre_reset_dec", dec_data, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_dec", dec_data, 0);
    check("async_rst_running", 32'(running), 0);
    check("async_rst_wrap", 32'(wrap), 0);
    step(2);
    rst_n = 1'b1;

    // simultaneous clear and start/stop: clear wins
    t6 = cyc; key_ss = 1'b0;
    goto(t6 + 8);  key_ss = 1'b1;
    goto(t6 + 27); check("both_pre_dec", dec_data, 2);
    t7 = cyc; key_ss = 1'b0; key_clr = 1'b0;
    goto(t7 + 6);  check("both_pre_running", 32'(running), 1);
    goto(t7 + 7);  check("both_running", 32'(running), 0);
    check("both_dec", dec_data, 0);
    goto(t7 + 8);  key_ss = 1'b1; key_clr = 1'b1;
    goto(t7 + 30); check("both_stay_idle", dec_data, 0);
    check("both_stay_running", 32'(running), 0);

    // lap freeze and release
    t8 = cyc; key_ss = 1'b0;
    goto(t8 + 8);  key_ss = 1'b1;
    goto(t8 + 37); check("lap_at3", dec_data, 3);
    key_lap = 1'b0;
    goto(t8 + 45); key_lap = 1'b1;
`ifdef STOPWATCH_LAP_EN
    goto(t8 + 86); check("lap_frozen", dec_data, 3);
`else
    goto(t8 + 86); check("lap_ignored", dec_data, 7);
`endif
    goto(t8 + 88); key_lap = 1'b0;
`ifdef STOPWATCH_LAP_EN
    goto(t8 + 94); check("lap_still_frozen", dec_data, 3);
`else
    goto(t8 + 94); check("lap_live", dec_data, 8);
`endif
    goto(t8 + 95); check("lap_release", dec_data, 8);
    goto(t8 + 96); key_lap = 1'b1;
    goto(t8 + 97); check("lap_after_release", dec_data, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
